// File: rtl/bp_index_ctrl_if.sv
// Fetch-side prediction and resolve-side update handshakes of the PHT index controller.
// The master side is the requester (fetch/resolve); the slave side is the controller.
interface bp_index_ctrl_if #(
    parameter int unsigned GHR_W = 10,
    parameter int unsigned PC_W  = 32
);
    logic             pred_req;
    logic [PC_W-1:0]  pred_pc;
    logic             pred_ready;
    logic             pred_valid;
    logic             pred_taken;
    logic [GHR_W-1:0] pred_ghr;

    logic             upd_req;
    logic [PC_W-1:0]  upd_pc;
    logic [GHR_W-1:0] upd_ghr;
    logic             upd_taken;
    logic             upd_ready;

    modport master (
        output pred_req, pred_pc, upd_req, upd_pc, upd_ghr, upd_taken,
        input  pred_ready, pred_valid, pred_taken, pred_ghr, upd_ready
    );

    modport slave (
        input  pred_req, pred_pc, upd_req, upd_pc, upd_ghr, upd_taken,
        output pred_ready, pred_valid, pred_taken, pred_ghr, upd_ready
    );
endinterface

// File: rtl/bp_index_ctrl.sv
// gshare PHT access controller: owns the global history and serialises prediction
// lookups and 2-bit counter read-modify-write updates onto a single PHT port.
module bp_index_ctrl #(
    parameter int unsigned GHR_W = 10,
    parameter int unsigned SET_W = 2,
    parameter int unsigned PC_W  = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    bp_index_ctrl_if.slave   bp_io,
    output logic [GHR_W-1:0] ghr_o,
    output logic             wr_en_o,
    output logic [1:0]       up_data_o,
    output logic [SET_W-1:0] set_addr_o,
    output logic [GHR_W-1:0] tab_addr_o,
    input  logic [1:0]       rd_data_i
);

    typedef enum logic [1:0] {StIdle, StRd, StCap, StWr} state_e;

    state_e           state_q, state_d;
    logic             op_upd_q, op_upd_d;
    logic             taken_q, taken_d;
    logic [SET_W-1:0] set_q, set_d;
    logic [GHR_W-1:0] tab_q, tab_d;
    logic [GHR_W-1:0] ghr_q, ghr_d;
    logic [GHR_W-1:0] pred_ghr_q, pred_ghr_d;
    logic             pred_taken_q, pred_taken_d;
    logic             pred_valid_q, pred_valid_d;
    logic [1:0]       up_data_q, up_data_d;

    logic             idle;
    logic             accept_upd;
    logic             accept_pred;
    logic [1:0]       sat_cnt;

    // PC bits outside the index fields carry no information for the PHT.
    logic unused_pc;
    assign unused_pc = ^{bp_io.pred_pc[PC_W-1:GHR_W+SET_W+2], bp_io.pred_pc[1:0],
                         bp_io.upd_pc[PC_W-1:GHR_W+SET_W+2], bp_io.upd_pc[1:0]};

    assign idle        = (state_q == StIdle);
    assign accept_upd  = idle & bp_io.upd_req;
    assign accept_pred = idle & bp_io.pred_req & ~bp_io.upd_req;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept_upd || accept_pred) state_d = StRd;
            StRd:    state_d = StCap;
            StCap:   state_d = op_upd_q ? StWr : StIdle;
            StWr:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        bp_io.upd_ready  = idle;
        bp_io.pred_ready = idle & ~bp_io.upd_req;
        wr_en_o          = (state_q == StWr);
    end

    always_comb begin
        if (taken_q) begin
            sat_cnt = (rd_data_i == 2'b11) ? 2'b11 : rd_data_i + 2'd1;
        end else begin
            sat_cnt = (rd_data_i == 2'b00) ? 2'b00 : rd_data_i - 2'd1;
        end
    end

    always_comb begin
        op_upd_d     = op_upd_q;
        taken_d      = taken_q;
        set_d        = set_q;
        tab_d        = tab_q;
        ghr_d        = ghr_q;
        pred_ghr_d   = pred_ghr_q;
        pred_taken_d = pred_taken_q;
        pred_valid_d = 1'b0;
        up_data_d    = up_data_q;

        if (accept_upd) begin
            op_upd_d = 1'b1;
            taken_d  = bp_io.upd_taken;
            set_d    = bp_io.upd_pc[GHR_W+SET_W+1:GHR_W+2];
            tab_d    = bp_io.upd_pc[GHR_W+1:2] ^ bp_io.upd_ghr;
        end else if (accept_pred) begin
            op_upd_d   = 1'b0;
            set_d      = bp_io.pred_pc[GHR_W+SET_W+1:GHR_W+2];
            tab_d      = bp_io.pred_pc[GHR_W+1:2] ^ ghr_q;
            pred_ghr_d = ghr_q;
        end

        if (state_q == StCap) begin
            if (op_upd_q) begin
                up_data_d = sat_cnt;
            end else begin
                pred_taken_d = rd_data_i[1];
                pred_valid_d = 1'b1;
            end
        end

        // History only advances once the counter write has been committed.
        if (state_q == StWr) begin
            ghr_d = {ghr_q[GHR_W-2:0], taken_q};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_upd_q     <= 1'b0;
            taken_q      <= 1'b0;
            set_q        <= '0;
            tab_q        <= '0;
            ghr_q        <= '0;
            pred_ghr_q   <= '0;
            pred_taken_q <= 1'b0;
            pred_valid_q <= 1'b0;
            up_data_q    <= 2'b00;
        end else begin
            op_upd_q     <= op_upd_d;
            taken_q      <= taken_d;
            set_q        <= set_d;
            tab_q        <= tab_d;
            ghr_q        <= ghr_d;
            pred_ghr_q   <= pred_ghr_d;
            pred_taken_q <= pred_taken_d;
            pred_valid_q <= pred_valid_d;
            up_data_q    <= up_data_d;
        end
    end

    assign bp_io.pred_valid = pred_valid_q;
    assign bp_io.pred_taken = pred_taken_q;
    assign bp_io.pred_ghr   = pred_ghr_q;
    assign ghr_o            = ghr_q;
    assign up_data_o        = up_data_q;
    assign set_addr_o       = set_q;
    assign tab_addr_o       = tab_q;

endmodule

// File: tb/tb_bp_index_ctrl.sv
// Bench for bp_index_ctrl: PHT memory stub plus an array/arithmetic reference of the
// counters and global history, driven by directed and random transactions.
module tb_bp_index_ctrl;
    localparam int unsigned GHR_W = 10;
    localparam int unsigned SET_W = 2;
    localparam int unsigned PC_W  = 32;
    localparam int unsigned NSET  = 1 << SET_W;
    localparam int unsigned NTAB  = 1 << GHR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bp_index_ctrl_if #(.GHR_W(GHR_W), .PC_W(PC_W)) bus ();

    logic [GHR_W-1:0] ghr;
    logic             wr_en;
    logic [1:0]       up_data;
    logic [SET_W-1:0] set_addr;
    logic [GHR_W-1:0] tab_addr;
    logic [1:0]       rd_data;

    bp_index_ctrl #(.GHR_W(GHR_W), .SET_W(SET_W), .PC_W(PC_W)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .bp_io     (bus),
        .ghr_o     (ghr),
        .wr_en_o   (wr_en),
        .up_data_o (up_data),
        .set_addr_o(set_addr),
        .tab_addr_o(tab_addr),
        .rd_data_i (rd_data)
    );

    // PHT stub: synchronous read, write on wr_en
    logic [1:0] mem     [NSET][NTAB];
    logic [1:0] ref_pht [NSET][NTAB];
    int unsigned ref_ghr;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) begin
        if (wr_en) mem[set_addr][tab_addr] = up_data;
        rd_data <= mem[set_addr][tab_addr];
    end

    function automatic int unsigned f_set(logic [31:0] pc);
        return (pc >> (GHR_W + 2)) % NSET;
    endfunction

    function automatic int unsigned f_tab(logic [31:0] pc, int unsigned h);
        return ((pc >> 2) % NTAB) ^ h;
    endfunction

    function automatic int unsigned f_sat(int unsigned c, bit t);
        if (t) return (c == 3) ? 3 : c + 1;
        return (c == 0) ? 0 : c - 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_stub(input int unsigned s, input int unsigned t, input logic [1:0] v);
        mem[s][t]     = v;
        ref_pht[s][t] = v;
    endtask

    task automatic do_pred(input logic [31:0] pc);
        int unsigned s, t, h;
        bus.pred_pc  = pc;
        bus.pred_req = 1'b1;
        #1;
        for (int i = 0; i < 10 && !bus.pred_ready; i++) tick();
        chk("pred_ready", 32'(bus.pred_ready), 32'd1);
        h = ref_ghr;
        s = f_set(pc);
        t = f_tab(pc, h);
        tick();
        bus.pred_req = 1'b0;
        chk("pred_rd_set", 32'(set_addr), s);
        chk("pred_rd_tab", 32'(tab_addr), t);
        chk("pred_rd_wr_en", 32'(wr_en), 32'd0);
        tick();
        chk("pred_cap_valid", 32'(bus.pred_valid), 32'd0);
        tick();
        chk("pred_valid", 32'(bus.pred_valid), 32'd1);
        chk("pred_taken", 32'(bus.pred_taken), 32'(ref_pht[s][t][1]));
        chk("pred_ghr", 32'(bus.pred_ghr), h);
        chk("pred_ghr_const", 32'(ghr), ref_ghr);
        tick();
        chk("pred_valid_drop", 32'(bus.pred_valid), 32'd0);
    endtask

    task automatic do_upd(input logic [31:0] pc, input int unsigned h, input bit taken);
        int unsigned s, t, nv;
        bus.upd_pc    = pc;
        bus.upd_ghr   = GHR_W'(h);
        bus.upd_taken = taken;
        bus.upd_req   = 1'b1;
        #1;
        chk("upd_ready", 32'(bus.upd_ready), 32'd1);
        chk("pred_blocked", 32'(bus.pred_ready), 32'd0);
        s  = f_set(pc);
        t  = f_tab(pc, h);
        nv = f_sat(ref_pht[s][t], taken);
        tick();
        bus.upd_req = 1'b0;
        chk("upd_rd_set", 32'(set_addr), s);
        chk("upd_rd_tab", 32'(tab_addr), t);
        chk("upd_rd_wr_en", 32'(wr_en), 32'd0);
        chk("upd_busy", 32'(bus.upd_ready), 32'd0);
        tick();
        chk("upd_cap_wr_en", 32'(wr_en), 32'd0);
        tick();
        chk("upd_wr_en", 32'(wr_en), 32'd1);
        chk("upd_data", 32'(up_data), nv);
        chk("upd_wr_set", 32'(set_addr), s);
        chk("upd_wr_tab", 32'(tab_addr), t);
        chk("upd_ghr_hold", 32'(ghr), ref_ghr);
        tick();
        ref_pht[s][t] = 2'(nv);
        ref_ghr       = ((ref_ghr << 1) | 32'(taken)) % NTAB;
        chk("upd_wr_en_drop", 32'(wr_en), 32'd0);
        chk("upd_ghr", 32'(ghr), ref_ghr);
        chk("upd_ready_back", 32'(bus.upd_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pred_req  = 1'b0;
        bus.pred_pc   = '0;
        bus.upd_req   = 1'b0;
        bus.upd_pc    = '0;
        bus.upd_ghr   = '0;
        bus.upd_taken = 1'b0;
        ref_ghr       = 0;
        for (int s = 0; s < int'(NSET); s++)
            for (int t = 0; t < int'(NTAB); t++)
                set_stub(s, t, 2'($urandom_range(0, 3)));

        // Reset state
        tick();
        tick();
        chk("rst_ghr", 32'(ghr), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_up_data", 32'(up_data), 32'd0);
        chk("rst_set", 32'(set_addr), 32'd0);
        chk("rst_tab", 32'(tab_addr), 32'd0);
        chk("rst_pred_valid", 32'(bus.pred_valid), 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_pred_ready", 32'(bus.pred_ready), 32'd1);
        chk("rst_upd_ready", 32'(bus.upd_ready), 32'd1);

        // Directed predict: pc 4 with ghr 0 hits set 0, entry 1
        set_stub(0, 1, 2'b10);
        do_pred(32'h0000_0004);

        // Saturation at both ends, then the two middle transitions
        set_stub(1, 0, 2'b11);
        do_upd(32'h0000_1FFC, 32'h3FF, 1'b1);
        chk("dir_ghr1", 32'(ghr), 32'h001);
        set_stub(1, 0, 2'b00);
        do_upd(32'h0000_1FFC, 32'h3FF, 1'b0);
        chk("dir_ghr2", 32'(ghr), 32'h002);
        set_stub(f_set(32'h0000_4008), f_tab(32'h0000_4008, 32'h155), 2'b01);
        do_upd(32'h0000_4008, 32'h155, 1'b1);
        set_stub(f_set(32'h0000_8AB0), f_tab(32'h0000_8AB0, 32'h0F0), 2'b10);
        do_upd(32'h0000_8AB0, 32'h0F0, 1'b0);

        // Simultaneous requests: update wins, prediction then sees the shifted history
        bus.pred_pc  = 32'h0000_0150;
        bus.pred_req = 1'b1;
        do_upd(32'h0000_3330, ref_ghr, 1'b1);
        do_pred(32'h0000_0150);

        // Randomised traffic
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 1) == 1)
                do_upd($urandom, $urandom_range(0, NTAB - 1), 1'($urandom_range(0, 1)));
            else
                do_pred($urandom);
        end

        // Reset during CAP of an update: no write may be issued
        bus.upd_pc    = $urandom;
        bus.upd_ghr   = GHR_W'(ref_ghr);
        bus.upd_taken = 1'b1;
        bus.upd_req   = 1'b1;
        tick();
        bus.upd_req = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_wr_en", 32'(wr_en), 32'd0);
        chk("arst_ghr", 32'(ghr), 32'd0);
        chk("arst_up_data", 32'(up_data), 32'd0);
        chk("arst_set", 32'(set_addr), 32'd0);
        chk("arst_tab", 32'(tab_addr), 32'd0);
        chk("arst_pred_ghr", 32'(bus.pred_ghr), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("arst_hold_wr_en", 32'(wr_en), 32'd0);
        end
        rst     = 1'b0;
        ref_ghr = 0;
        tick();
        chk("arst_idle_upd", 32'(bus.upd_ready), 32'd1);
        chk("arst_idle_pred", 32'(bus.pred_ready), 32'd1);
        chk("arst_ghr_after", 32'(ghr), 32'd0);

        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 1) == 1)
                do_upd($urandom, ref_ghr, 1'($urandom_range(0, 1)));
            else
                do_pred($urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
